// File: rtl/mul_table_pkg.sv
// Shared definitions for the multiply-table loader: state encoding,
// default geometry and the reference rule for one table entry.
package mul_table_pkg;

    // Default table geometry: 64 entries of 8 bits.
    localparam int MT_AW = 6;
    localparam int MT_DW = 8;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } mt_state_e;

    // Table entry for an address: upper half times lower half, unsigned.
    // The result is returned zero-extended to 32 bits; callers truncate.
    function automatic logic [31:0] mt_entry(input logic [31:0] addr,
                                             input int unsigned aw);
        logic [31:0] half_mask;
        logic [31:0] op_hi;
        logic [31:0] op_lo;
        half_mask = (32'd1 << (aw / 32'd2)) - 32'd1;
        op_hi     = (addr >> (aw / 32'd2)) & half_mask;
        op_lo     = addr & half_mask;
        return op_hi * op_lo;
    endfunction

endpackage

// File: rtl/mul_table_entry.sv
// Combinational table-entry generator: address in, zero-extended
// product of its two halves out. Feeds both the write data and the
// expected value used during read-back.
module mul_table_entry
    import mul_table_pkg::*;
#(
    parameter int AW = MT_AW,
    parameter int DW = MT_DW
) (
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] o_data
);

    // The product of two AW/2-bit operands fits in AW bits, and DW >= AW,
    // so truncating the 32-bit helper result to DW bits loses nothing.
    assign o_data = DW'(mt_entry(32'(i_addr), AW));

endmodule

// File: rtl/mul_table_writer.sv
// Multiply-table loader. On START it writes every RAM entry with the
// product of its address halves, optionally reads the whole table back
// and flags the first address whose data disagrees. All outputs are
// registered from the current state, so pins lag the state by a cycle.
module mul_table_writer
    import mul_table_pkg::*;
#(
    parameter int AW     = MT_AW,
    parameter int DW     = MT_DW,
    parameter bit VERIFY = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic          ERR,
    output logic [AW-1:0] ERR_ADDR,
    output logic          CS,
    output logic          WR,
    output logic          RD,
    output logic [AW-1:0] ADDRESS,
    output logic [DW-1:0] DATA_OUT,
    input  logic [DW-1:0] DATA_IN
);

    localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};
    localparam logic [AW-1:0] CNT_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0] CNT_ONE  = {{(AW-1){1'b0}}, 1'b1};

    // Sequencer state and address counter.
    mt_state_e     r_state;
    mt_state_e     w_next_state;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_next;
    logic          w_accept;

    // Per-state pin decode, registered below.
    logic          w_busy;
    logic          w_done;
    logic          w_wr;
    logic          w_rd;
    logic          w_drive_addr;

    // Table entry for the current counter value.
    logic [DW-1:0] w_entry;

    // Registered pins.
    logic          r_busy;
    logic          r_done;
    logic          r_cs;
    logic          r_wr;
    logic          r_rd;
    logic [AW-1:0] r_address;
    logic [DW-1:0] r_data_out;
    logic          r_err;
    logic [AW-1:0] r_err_addr;

    // Read-back pipeline: r_exp travels with r_address; the r_chk_*
    // stage lines it up with DATA_IN one cycle after RD was presented.
    logic [DW-1:0] r_exp;
    logic          r_chk_vld;
    logic [AW-1:0] r_chk_addr;
    logic [DW-1:0] r_chk_exp;
    logic          w_mismatch;

    mul_table_entry #(
        .AW (AW),
        .DW (DW)
    ) u_entry (
        .i_addr (r_cnt),
        .o_data (w_entry)
    );

    // Next-state and counter logic; the counter only wraps on a phase change.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (START) begin
                    w_next_state = ST_WRITE;
                    w_cnt_next   = CNT_ZERO;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = CNT_ZERO;
                    w_next_state = VERIFY ? ST_READ : ST_FIN;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_READ: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_next   = CNT_ZERO;
                    w_next_state = ST_CHECK;
                end else begin
                    w_cnt_next   = r_cnt + CNT_ONE;
                end
            end
            ST_CHECK: begin
                w_next_state = ST_FIN;
            end
            ST_FIN: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_cnt_next   = CNT_ZERO;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_cnt   <= CNT_ZERO;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
        end
    end

    // Pin decode for the current state; WR and RD come from disjoint states.
    always_comb begin
        w_busy       = 1'b0;
        w_done       = 1'b0;
        w_wr         = 1'b0;
        w_rd         = 1'b0;
        w_drive_addr = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
            end
            ST_WRITE: begin
                w_busy       = 1'b1;
                w_wr         = 1'b1;
                w_drive_addr = 1'b1;
            end
            ST_READ: begin
                w_busy       = 1'b1;
                w_rd         = 1'b1;
                w_drive_addr = 1'b1;
            end
            ST_CHECK: begin
                w_busy = 1'b1;
            end
            ST_FIN: begin
                w_done = 1'b1;
            end
            default: begin
                w_busy = 1'b0;
            end
        endcase
    end

    // Register the RAM pins, status pins and the expected value for each address.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_address  <= CNT_ZERO;
            r_data_out <= {DW{1'b0}};
            r_exp      <= {DW{1'b0}};
        end else begin
            r_busy <= w_busy;
            r_done <= w_done;
            r_cs   <= w_wr | w_rd;
            r_wr   <= w_wr;
            r_rd   <= w_rd;
            if (w_drive_addr) begin
                r_address <= r_cnt;
                r_exp     <= w_entry;
            end
            if (w_wr) begin
                r_data_out <= w_entry;
            end
        end
    end

    // Delay the issued address and its expected data to meet the returning read data.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_chk_vld  <= 1'b0;
            r_chk_addr <= CNT_ZERO;
            r_chk_exp  <= {DW{1'b0}};
        end else begin
            r_chk_vld  <= r_rd;
            r_chk_addr <= r_address;
            r_chk_exp  <= r_exp;
        end
    end

    assign w_mismatch = r_chk_vld && (DATA_IN != r_chk_exp);

    // Sticky error flag that keeps the first failing address; cleared on a new load.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_err      <= 1'b0;
            r_err_addr <= CNT_ZERO;
        end else if (w_accept) begin
            r_err      <= 1'b0;
            r_err_addr <= CNT_ZERO;
        end else if (w_mismatch && !r_err) begin
            r_err      <= 1'b1;
            r_err_addr <= r_chk_addr;
        end
    end

    assign BUSY     = r_busy;
    assign DONE     = r_done;
    assign ERR      = r_err;
    assign ERR_ADDR = r_err_addr;
    assign CS       = r_cs;
    assign WR       = r_wr;
    assign RD       = r_rd;
    assign ADDRESS  = r_address;
    assign DATA_OUT = r_data_out;

endmodule

// File: tb/tb_mul_table_writer.sv
// Scoreboard bench for mul_table_writer: one verifying instance with a
// synchronous RAM model that can corrupt read data, and one
// non-verifying instance with its own RAM.
module tb_mul_table_writer;

    localparam int AW     = 6;
    localparam int DW     = 8;
    localparam int N      = 64;
    localparam int LAT_V  = 130;
    localparam int LAT_NV = 65;

    typedef struct {
        int             cyc;
        logic           err;
        logic [AW-1:0]  ea;
    } done_t;

    logic          CLK = 1'b0;
    logic          RST;
    logic          START;
    logic          START0;

    logic          BUSY, DONE, ERR, CS, WR, RD;
    logic [AW-1:0] ERR_ADDR, ADDRESS;
    logic [DW-1:0] DATA_OUT, DATA_IN;

    logic          BUSY0, DONE0, ERR0, CS0, WR0, RD0;
    logic [AW-1:0] ERR_ADDR0, ADDRESS0;
    logic [DW-1:0] DATA_OUT0, DATA_IN0;

    logic [DW-1:0] mem  [N];
    logic [DW-1:0] mem0 [N];
    logic [DW-1:0] corr [N];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_at  = 0;
    int ready0_at = 0;
    int busy_cnt  = 0;
    int busy0_cnt = 0;
    int last_done_cyc = -1;
    logic wr_rd_both = 1'b0;
    logic rd0_seen   = 1'b0;

    logic [AW-1:0] wa_q[$];
    logic [DW-1:0] wd_q[$];
    done_t         done_q[$];
    int            err_rise_q[$];
    int            done0_q[$];

    always #5 CLK = ~CLK;

    mul_table_writer #(.AW(AW), .DW(DW), .VERIFY(1'b1)) dut (
        .CLK(CLK), .RST(RST), .START(START), .BUSY(BUSY), .DONE(DONE),
        .ERR(ERR), .ERR_ADDR(ERR_ADDR), .CS(CS), .WR(WR), .RD(RD),
        .ADDRESS(ADDRESS), .DATA_OUT(DATA_OUT), .DATA_IN(DATA_IN)
    );

    mul_table_writer #(.AW(AW), .DW(DW), .VERIFY(1'b0)) dut0 (
        .CLK(CLK), .RST(RST), .START(START0), .BUSY(BUSY0), .DONE(DONE0),
        .ERR(ERR0), .ERR_ADDR(ERR_ADDR0), .CS(CS0), .WR(WR0), .RD(RD0),
        .ADDRESS(ADDRESS0), .DATA_OUT(DATA_OUT0), .DATA_IN(DATA_IN0)
    );

    // Synchronous RAM models: read data appears the cycle after RD is sampled.
    always @(posedge CLK) begin
        if (CS && WR) mem[ADDRESS] <= DATA_OUT;
        if (CS && RD) DATA_IN <= mem[ADDRESS] ^ corr[ADDRESS];
        if (CS0 && WR0) mem0[ADDRESS0] <= DATA_OUT0;
        if (CS0 && RD0) DATA_IN0 <= mem0[ADDRESS0];
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic event_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
    endtask

    // Reference model: decides acceptance from the published latencies and
    // queues the whole expected response of a load at the accepting edge.
    initial begin : model
        logic          found;
        logic [AW-1:0] fa;
        forever begin
            @(posedge CLK);
            cyc = cyc + 1;
            if (!RST && START && cyc >= ready_at) begin
                ready_at = cyc + LAT_V + 1;
                found = 1'b0;
                fa    = '0;
                for (int a = 0; a < N; a++) begin
                    wa_q.push_back(AW'(a));
                    wd_q.push_back(DW'((a / 8) * (a % 8)));
                    if (!found && corr[a] != 8'h00) begin
                        found = 1'b1;
                        fa    = AW'(a);
                    end
                end
                done_q.push_back('{cyc + LAT_V, found, fa});
                if (found) err_rise_q.push_back(cyc + 67 + int'(fa));
            end
            if (!RST && START0 && cyc >= ready0_at) begin
                ready0_at = cyc + LAT_NV + 1;
                done0_q.push_back(cyc + LAT_NV);
            end
        end
    end

    // Monitor: samples on the falling edge and pops expectations as outputs appear.
    initial begin : monitor
        logic          err_prev;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        done_t         d;
        int            d0;
        err_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (WR && RD) wr_rd_both = 1'b1;
            if (RD0) rd0_seen = 1'b1;
            if (BUSY) busy_cnt++;
            if (BUSY0) busy0_cnt++;
            if (CS && WR) begin
                if (wa_q.size() == 0) begin
                    event_fail("write");
                end else begin
                    ea = wa_q.pop_front();
                    ed = wd_q.pop_front();
                    check("write", {ADDRESS, DATA_OUT}, {ea, ed});
                end
            end
            if (ERR && !err_prev) begin
                if (err_rise_q.size() == 0) begin
                    event_fail("err_rise");
                end else begin
                    check("err_rise_cycle", cyc, err_rise_q.pop_front());
                end
            end
            err_prev = ERR;
            if (DONE) begin
                last_done_cyc = cyc;
                if (done_q.size() == 0) begin
                    event_fail("done");
                end else begin
                    d = done_q.pop_front();
                    check("done_cycle", cyc, d.cyc);
                    check("done_err", {ERR, ERR_ADDR}, {d.err, d.ea});
                    check("busy_len", busy_cnt, 129);
                end
                busy_cnt = 0;
            end
            if (DONE0) begin
                if (done0_q.size() == 0) begin
                    event_fail("done0");
                end else begin
                    d0 = done0_q.pop_front();
                    check("done0_cycle", cyc, d0);
                    check("done0_err", {ERR0, ERR_ADDR0}, 0);
                    check("busy0_len", busy0_cnt, 64);
                end
                busy0_cnt = 0;
            end
        end
    end

    task automatic pulse_start();
        @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((done_q.size() != 0 || done0_q.size() != 0) && n < 400) begin
            @(posedge CLK);
            n++;
        end
        if (n >= 400) event_fail("wait_idle_timeout");
        repeat (3) @(posedge CLK);
        #1;
    endtask

    task automatic clear_corr();
        for (int a = 0; a < N; a++) corr[a] = 8'h00;
    endtask

    // Stimulus.
    initial begin : stim
        int n;
        int wrong;
        int wrong0;
        RST    = 1'b1;
        START  = 1'b0;
        START0 = 1'b0;
        clear_corr();

        // Reset values.
        @(posedge CLK);
        #1 check("reset_outputs",
                 {BUSY, DONE, ERR, CS, WR, RD, ERR_ADDR, ADDRESS, DATA_OUT}, 0);
        @(posedge CLK);
        #1 RST = 1'b0;

        // Clean load with START sampled at edge 5.
        repeat (2) @(posedge CLK);
        #1 START = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0;
        wait_idle();
        check("t1_done_at_135", last_done_cyc, 135);
        check("t1_err", ERR, 1'b0);
        check("ram_1d", mem[6'h1D], 8'h0F);
        check("ram_3f", mem[6'h3F], 8'h31);
        check("ram_07", mem[6'h07], 8'h00);

        // Single corrupted read-back.
        corr[6'h12] = 8'h01;
        pulse_start();
        wait_idle();
        check("t2_err_addr", {ERR, ERR_ADDR}, {1'b1, 6'h12});

        // Two corruptions keep the first address; a clean reload clears ERR.
        corr[6'h30] = 8'h40;
        pulse_start();
        wait_idle();
        clear_corr();
        pulse_start();
        wait_idle();
        check("t3_err_cleared", ERR, 1'b0);

        // Asynchronous reset in the middle of the write phase.
        pulse_start();
        n = 0;
        while (!(WR && ADDRESS == 6'h14) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) event_fail("t4_wait_addr14");
        #2 RST = 1'b1;
        #1 check("t4_async_drop", {CS, WR, BUSY, DONE}, 4'b0000);
        wa_q.delete();
        wd_q.delete();
        done_q.delete();
        err_rise_q.delete();
        busy_cnt = 0;
        ready_at = 0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        pulse_start();
        wait_idle();

        // START pulses while busy are ignored; the non-verifying copy runs alongside.
        @(posedge CLK);
        #1 START = 1'b1; START0 = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0; START0 = 1'b0;
        repeat ($urandom_range(10, 40)) @(posedge CLK);
        #1 START = 1'b1; START0 = 1'b1;
        @(posedge CLK);
        #1 START = 1'b0; START0 = 1'b0;
        repeat ($urandom_range(60, 80)) @(posedge CLK);
        pulse_start();
        wait_idle();

        // START held high re-triggers only after each return to IDLE.
        @(posedge CLK);
        #1 START = 1'b1;
        repeat (300) @(posedge CLK);
        #1 START = 1'b0;
        wait_idle();

        // Randomised corruption patterns and start gaps.
        for (int it = 0; it < 4; it++) begin
            clear_corr();
            for (int j = 0; j < int'($urandom_range(0, 2)); j++)
                corr[$urandom_range(0, N - 1)] = DW'($urandom_range(1, 255));
            repeat ($urandom_range(1, 6)) @(posedge CLK);
            pulse_start();
            wait_idle();
        end

        // Final table contents and global properties.
        wrong  = 0;
        wrong0 = 0;
        for (int a = 0; a < N; a++) begin
            if (mem[a]  !== DW'((a / 8) * (a % 8))) wrong++;
            if (mem0[a] !== DW'((a / 8) * (a % 8))) wrong0++;
        end
        check("table_wrong_entries", wrong, 0);
        check("table0_wrong_entries", wrong0, 0);
        check("wr_rd_overlap", wr_rd_both, 1'b0);
        check("rd0_asserted", rd0_seen, 1'b0);
        check("write_q_left", wa_q.size(), 0);
        check("err_rise_q_left", err_rise_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mul_table_writer.md
Name: mul_table_writer

Overview:
Writer/loader for the 64x8 multiply lookup table; the write-side counterpart of the table-read path. On START it fills a synchronous single-port RAM so each entry holds ADDRESS[5:3]*ADDRESS[2:0], zero-extended to 8 bits. Optionally it reads every entry back and checks it. It sits between control logic and the table RAM, and drives the RAM's CS/WR/RD, ADDRESS and write-data pins.

Parameters:
AW, 6, RAM address width; must be even; operand width is AW/2
DW, 8, RAM data width; must be >= AW
VERIFY, 1, 1 = run the read-back check after the write phase; 0 = skip the check

Ports:
CLK  input  1  system clock, rising edge
RST  input  1  asynchronous, active-high reset
START  input  1  one-cycle request to (re)load the table; sampled only in IDLE
BUSY  output  1  high while a load or check is in progress
DONE  output  1  one-cycle pulse when the sequence finishes
ERR  output  1  sticky mismatch flag; cleared by an accepted START
ERR_ADDR  output  AW  address of the first mismatch; valid while ERR=1
CS  output  1  RAM chip select
WR  output  1  RAM write enable
RD  output  1  RAM read enable
ADDRESS  output  AW  RAM address
DATA_OUT  output  DW  RAM write data
DATA_IN  input  DW  RAM read data; valid in the cycle after RD is sampled

Behaviour:
- Interface: one clock CLK; reset RST is asynchronous and active-high.
- Reset (async, takes effect immediately, including mid-operation):
  - state=IDLE
  - BUSY, DONE, ERR, CS, WR, RD = 0
  - ADDRESS, DATA_OUT, ERR_ADDR = 0
  - address counter = 0
  - the RAM contents are left partially written; no cleanup is done.
- All outputs are registered.
- FSM states and transitions:
  - IDLE: START=1 -> WRITE; counter=0; ERR, ERR_ADDR cleared.
  - WRITE: each cycle drives CS=1, WR=1, RD=0, ADDRESS=cnt, DATA_OUT=zext(cnt[AW-1:AW/2]*cnt[AW/2-1:0]).
    - Runs exactly 2^AW cycles.
    - After cnt = 2^AW-1: if VERIFY=1 -> READ with cnt=0, else -> FIN.
  - READ: each cycle drives CS=1, RD=1, WR=0, ADDRESS=cnt.
    - Runs 2^AW cycles, then -> CHECK.
  - CHECK: one drain cycle with CS=RD=0; compares the last read-back value; then -> FIN.
  - FIN: DONE=1 for exactly one cycle, BUSY=0, then -> IDLE.
- Read-back pipeline:
  - The expected value for the address issued in cycle t is registered and compared with DATA_IN in cycle t+1.
  - On mismatch with ERR=0: set ERR=1 and load ERR_ADDR with the address issued in cycle t.
  - Later mismatches do not change ERR_ADDR.
- Timing:
  - BUSY=1 from the cycle after START is accepted through the CHECK cycle.
  - CS, WR and RD are all 0 in IDLE and FIN.
- Latency, counted from the accepting edge:
  - DONE rises 2^AW+2^AW+2 = 130 cycles later when VERIFY=1.
  - DONE rises 2^AW+1 = 65 cycles later when VERIFY=0.
- Boundary conditions:
  - START while BUSY or in FIN is ignored.
  - START held high re-triggers only on return to IDLE.
  - The counter wraps 2^AW-1 -> 0 only on a phase change.
  - WR and RD are never high in the same cycle.
- Arithmetic: the product is AW bits unsigned and zero-extended to DW. Maximum value 7*7 = 49 = 8'h31.

Decomposition:
- Package mul_table_pkg holds:
  - the FSM state encoding (IDLE, WRITE, READ, CHECK, FIN)
  - default AW/DW constants
  - a function computing the table entry for a given address
- One natural sub-module: mul_table_entry. It is combinational: address in, zero-extended product out. It is shared by the write-data path and the expected-value path.
- Counter, FSM and compare logic stay in the top module.

Test Plan:
1. RST pulse, then START at cycle 5 with VERIFY=1 and a behavioural synchronous RAM model (data valid one cycle after RD) -> expected response:
   - BUSY high for 129 cycles; DONE single pulse at cycle 135; ERR=0
   - RAM[6'h1D]=8'h0F (3*5), RAM[6'h3F]=8'h31, RAM[6'h07]=8'h00.
2. RAM model forces RAM[6'h12] to read back 8'h05 (expected 8'h04) -> expected response:
   - ERR=1 one cycle after the read of 6'h12; ERR_ADDR=6'h12
   - DONE still pulses at the normal cycle.
3. RAM model corrupts both 6'h12 and 6'h30 -> expected response: ERR_ADDR stays 6'h12. A following START clears ERR; with a clean RAM, ERR ends at 0.
4. RST asserted asynchronously mid-write at ADDRESS=6'h14 -> expected response:
   - CS, WR, BUSY drop before the next clock edge; no DONE
   - a new START reloads the full table correctly.
5. START pulses during WRITE and during READ -> both ignored; exactly one DONE pulse. With VERIFY=0: RD never asserted, DONE 65 cycles after acceptance.
